// File: rtl/mine_placer.sv
// Mine placer: an LFSR rejection sampler that writes distinct mine cells to a board store, never on the first click.
// Define MINE_SAFE_ZONE_EN to exclude the clipped 3x3 block around the click instead of the single cell.

module mine_placer #(
  parameter int LFSR_WIDTH = 16,
  parameter int COORD_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [COORD_W:0]      board_size,
  input  logic [2*COORD_W:0]    mine_count,
  input  logic [COORD_W-1:0]    safe_x,
  input  logic [COORD_W-1:0]    safe_y,
  output logic                  mine_valid,
  input  logic                  mine_ready,
  output logic [COORD_W-1:0]    mine_x,
  output logic [COORD_W-1:0]    mine_y,
  output logic                  busy,
  output logic                  done
);
  localparam int CW2   = 2*COORD_W;
  localparam int CELLS = 1 << CW2;

  function automatic logic [63:0] tap(input int t);
    return 64'd1 << (t-1);
  endfunction

  // XAPP052 maximal-length tap sets, bit t-1 set for each tap t
  function automatic logic [63:0] tap_mask(input int w);
    logic [63:0] m;
    case (w)
      8:  m = tap(8)|tap(6)|tap(5)|tap(4);     9:  m = tap(9)|tap(5);
      10: m = tap(10)|tap(7);                  11: m = tap(11)|tap(9);
      12: m = tap(12)|tap(6)|tap(4)|tap(1);    13: m = tap(13)|tap(4)|tap(3)|tap(1);
      14: m = tap(14)|tap(5)|tap(3)|tap(1);    15: m = tap(15)|tap(14);
      16: m = tap(16)|tap(15)|tap(13)|tap(4);  17: m = tap(17)|tap(14);
      18: m = tap(18)|tap(11);                 19: m = tap(19)|tap(6)|tap(2)|tap(1);
      20: m = tap(20)|tap(17);                 21: m = tap(21)|tap(19);
      22: m = tap(22)|tap(21);                 23: m = tap(23)|tap(18);
      24: m = tap(24)|tap(23)|tap(22)|tap(17); 25: m = tap(25)|tap(22);
      26: m = tap(26)|tap(6)|tap(2)|tap(1);    27: m = tap(27)|tap(5)|tap(2)|tap(1);
      28: m = tap(28)|tap(25);                 29: m = tap(29)|tap(27);
      30: m = tap(30)|tap(6)|tap(4)|tap(1);    31: m = tap(31)|tap(28);
      32: m = tap(32)|tap(22)|tap(2)|tap(1);   33: m = tap(33)|tap(20);
      34: m = tap(34)|tap(27)|tap(2)|tap(1);   35: m = tap(35)|tap(33);
      36: m = tap(36)|tap(25);
      37: m = tap(37)|tap(5)|tap(4)|tap(3)|tap(2)|tap(1);
      38: m = tap(38)|tap(6)|tap(5)|tap(1);    39: m = tap(39)|tap(35);
      40: m = tap(40)|tap(38)|tap(21)|tap(19); 41: m = tap(41)|tap(38);
      42: m = tap(42)|tap(41)|tap(20)|tap(19); 43: m = tap(43)|tap(42)|tap(38)|tap(37);
      44: m = tap(44)|tap(43)|tap(18)|tap(17); 45: m = tap(45)|tap(44)|tap(42)|tap(41);
      46: m = tap(46)|tap(45)|tap(26)|tap(25); 47: m = tap(47)|tap(42);
      48: m = tap(48)|tap(47)|tap(21)|tap(20); 49: m = tap(49)|tap(40);
      50: m = tap(50)|tap(49)|tap(24)|tap(23); 51: m = tap(51)|tap(50)|tap(36)|tap(35);
      52: m = tap(52)|tap(49);                 53: m = tap(53)|tap(52)|tap(38)|tap(37);
      54: m = tap(54)|tap(53)|tap(18)|tap(17); 55: m = tap(55)|tap(31);
      56: m = tap(56)|tap(55)|tap(35)|tap(34); 57: m = tap(57)|tap(50);
      58: m = tap(58)|tap(39);                 59: m = tap(59)|tap(58)|tap(38)|tap(37);
      60: m = tap(60)|tap(59);                 61: m = tap(61)|tap(60)|tap(46)|tap(45);
      62: m = tap(62)|tap(61)|tap(6)|tap(5);   63: m = tap(63)|tap(62);
      default: m = tap(64)|tap(63)|tap(61)|tap(60);
    endcase
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(tap_mask(LFSR_WIDTH));

`ifdef MINE_SAFE_ZONE_EN
  // Number of board columns (or rows) within +-1 of c, clipped to [0, n-1]
  function automatic logic [1:0] span(input logic [COORD_W-1:0] c, input logic [COORD_W:0] n);
    int lo, hi;
    lo = (c == '0) ? 0 : int'(c) - 1;
    hi = int'(c) + 1;
    if (hi > int'(n) - 1) hi = int'(n) - 1;
    return (hi < lo) ? 2'd0 : 2'(hi - lo + 1);
  endfunction

  function automatic logic near(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] s);
    logic [COORD_W:0] a, b;
    a = {1'b0, c};
    b = {1'b0, s};
    return (a == b) || (a + 1'b1 == b) || (a == b + 1'b1);
  endfunction
`endif

  typedef enum logic [2:0] {IDLE, SEED, RUN, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, seed_q, lfsr_step;
  logic [COORD_W:0]      n_q;
  logic [CW2:0]          mc_q, placed_q, target_q;
  logic [COORD_W-1:0]    sx_q, sy_q, mx_q, my_q, cx, cy;
  logic [CELLS-1:0]      bitmap_q;
  logic [CW2+1:0]        nn;
  logic [CW2:0]          zone, avail, tgt;
  logic                  excl, cand_ok, last;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign cx        = lfsr_q[COORD_W-1:0];
  assign cy        = lfsr_q[CW2-1:COORD_W];
  assign nn        = (CW2+2)'(n_q) * (CW2+2)'(n_q);

`ifdef MINE_SAFE_ZONE_EN
  assign zone = (CW2+1)'(span(sx_q, n_q)) * (CW2+1)'(span(sy_q, n_q));
  assign excl = near(cx, sx_q) && near(cy, sy_q);
`else
  assign zone = (CW2+1)'(1);
  assign excl = (cx == sx_q) && (cy == sy_q);
`endif

  // Clamp at zero so an empty board never wraps into a huge target
  assign avail   = (nn > (CW2+2)'(zone)) ? (CW2+1)'(nn - (CW2+2)'(zone)) : '0;
  assign tgt     = (mc_q < avail) ? mc_q : avail;
  assign cand_ok = ({1'b0, cx} < n_q) && ({1'b0, cy} < n_q) && !bitmap_q[{cy, cx}] && !excl;
  assign last    = (placed_q + (CW2+1)'(1)) == target_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEED;
      SEED:    state_d = ((tgt == '0) || (n_q == '0)) ? DONE : RUN;
      RUN:     if (cand_ok) state_d = WRITE;
      WRITE:   if (mine_ready) state_d = last ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_WIDTH'(1);
      seed_q   <= '0;
      n_q      <= '0;
      mc_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      placed_q <= '0;
      target_q <= '0;
      bitmap_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          seed_q   <= seed;
          n_q      <= board_size;
          mc_q     <= mine_count;
          sx_q     <= safe_x;
          sy_q     <= safe_y;
          bitmap_q <= '0;
          placed_q <= '0;
        end
        SEED: begin
          lfsr_q   <= (seed_q == '0) ? LFSR_WIDTH'(1) : seed_q;
          target_q <= tgt;
        end
        RUN: begin
          lfsr_q <= lfsr_step;
          if (cand_ok) begin
            mx_q <= cx;
            my_q <= cy;
          end
        end
        WRITE: if (mine_ready) begin
          bitmap_q[{my_q, mx_q}] <= 1'b1;
          placed_q               <= placed_q + (CW2+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign mine_valid = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mine_x     = mx_q;
  assign mine_y     = my_q;

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: handshake capture, mine-set properties and hand-computed first mine.
module tb_mine_placer;
  logic        clk = 1'b0;
  logic        rst_n, start, mine_valid, mine_ready, busy, done;
  logic [15:0] seed;
  logic [4:0]  board_size;
  logic [8:0]  mine_count;
  logic [3:0]  safe_x, safe_y, mine_x, mine_y;

  int checks = 0;
  int errors = 0;

  mine_placer #(.LFSR_WIDTH(16), .COORD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .board_size(board_size),
    .mine_count(mine_count), .safe_x(safe_x), .safe_y(safe_y), .mine_valid(mine_valid),
    .mine_ready(mine_ready), .mine_x(mine_x), .mine_y(mine_y), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "global timeout");
  end

  // Handshakes are taken on the falling edge; inputs only change just after a rising edge
  logic [7:0] cap[$];
  int n_done = 0;
  int mv_cnt = 0;
  always @(negedge clk) begin
    if (mine_valid && mine_ready) cap.push_back({mine_y, mine_x});
    if (done) n_done <= n_done + 1;
    if (mine_valid) mv_cnt <= mv_cnt + 1;
  end

  logic [7:0] got[$];
  logic [7:0] ref_q[$];
  int got_done, got_mv;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_excl(input int x, input int y, input int sx, input int sy);
`ifdef MINE_SAFE_ZONE_EN
    return (x - sx <= 1) && (sx - x <= 1) && (y - sy <= 1) && (sy - y <= 1);
`else
    return (x == sx) && (y == sy);
`endif
  endfunction

  task automatic collect(input int b0, input int d0, input int v0);
    got.delete();
    for (int i = b0; i < cap.size(); i++) got.push_back(cap[i]);
    got_done = n_done - d0;
    got_mv   = mv_cnt - v0;
  endtask

  task automatic wait_done(input int d0, output int lat);
    lat = 0;
    while (n_done == d0 && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_timeout", lat < 20000, 1);
  endtask

  task automatic do_run(input logic [15:0] sd, input logic [4:0] n, input logic [8:0] mc,
                        input logic [3:0] sx, input logic [3:0] sy, output int lat);
    int b0, d0, v0;
    @(posedge clk); #1;
    b0 = cap.size(); d0 = n_done; v0 = mv_cnt;
    seed = sd; board_size = n; mine_count = mc; safe_x = sx; safe_y = sy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, lat);
    repeat (3) @(posedge clk);
    #1;
    collect(b0, d0, v0);
  endtask

  task automatic check_mines(input string tag, input int n, input int exp_cnt,
                             input int sx, input int sy);
    int rng = 0, dup = 0, exc = 0;
    logic [255:0] seen = '0;
    foreach (got[i]) begin
      if (int'(got[i][3:0]) >= n || int'(got[i][7:4]) >= n) rng++;
      if (seen[got[i]]) dup++;
      seen[got[i]] = 1'b1;
      if (is_excl(int'(got[i][3:0]), int'(got[i][7:4]), sx, sy)) exc++;
    end
    chk({tag, "_count"}, got.size(), exp_cnt);
    chk({tag, "_dup"}, dup, 0);
    chk({tag, "_range"}, rng, 0);
    chk({tag, "_excl"}, exc, 0);
    chk({tag, "_done"}, got_done, 1);
  endtask

  function automatic int q_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int d = (a.size() == b.size()) ? 0 : 1;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  initial begin
    int lat, b0, d0, v0, k, bad;
    logic [8:0] cov;
    logic [7:0] q0[$];
    logic [3:0] hx, hy;

    rst_n = 1'b0; start = 1'b0; mine_ready = 1'b1; seed = '0; board_size = '0;
    mine_count = '0; safe_x = '0; safe_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", mine_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xy", {mine_y, mine_x}, 0);
    rst_n = 1'b1;

    // 8x8, 10 mines; first accepted LFSR state from 16'hACE1 is 16'h8E17 -> (7,1)
    do_run(16'hACE1, 5'd8, 9'd10, 4'd3, 4'd3, lat);
    check_mines("b8", 8, 10, 3, 3);
    chk("b8_first", (got.size() > 0) ? got[0] : 8'hFF, 8'h17);
    ref_q = got;

    // 3x3 board, far more mines requested than cells available
    do_run(16'h1234, 5'd3, 9'd20, 4'd1, 4'd1, lat);
`ifdef MINE_SAFE_ZONE_EN
    chk("b3_count", got.size(), 0);
    chk("b3_lat", lat <= 3, 1);
    chk("b3_done", got_done, 1);
`else
    check_mines("b3", 3, 8, 1, 1);
    cov = '0;
    foreach (got[i]) if (got[i][3:0] < 3 && got[i][7:4] < 3)
      cov[int'(got[i][7:4]) * 3 + int'(got[i][3:0])] = 1'b1;
    chk("b3_cover", cov, 9'h1EF);
`endif

    // Zero seed behaves as seed 1
    do_run(16'h0000, 5'd16, 9'd40, 4'd0, 4'd0, lat);
    check_mines("s0", 16, 40, 0, 0);
    q0 = got;
    do_run(16'h0001, 5'd16, 9'd40, 4'd0, 4'd0, lat);
    chk("s1_count", got.size(), 40);
    chk("s0_vs_s1", q_diff(q0, got), 0);

    // No mines requested
    do_run(16'hBEEF, 5'd8, 9'd0, 4'd2, 4'd2, lat);
    chk("z_lat", lat, 2);
    chk("z_valid", got_mv, 0);
    chk("z_done", got_done, 1);

    // Backpressure in WRITE, with a start pulse that must be ignored
    @(posedge clk); #1;
    b0 = cap.size(); d0 = n_done; v0 = mv_cnt;
    mine_ready = 1'b0; seed = 16'hACE1; board_size = 5'd8; mine_count = 9'd3;
    safe_x = 4'd3; safe_y = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!mine_valid && k < 1000) begin @(posedge clk); #1; k++; end
    chk("bp_valid", mine_valid, 1);
    chk("bp_first", {mine_y, mine_x}, 8'h17);
    hx = mine_x; hy = mine_y; bad = 0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      if (c == 2) begin board_size = 5'd16; mine_count = 9'd1; seed = 16'h0042; end
      @(posedge clk); #1;
      if (!mine_valid || mine_x != hx || mine_y != hy) bad++;
    end
    start = 1'b0; board_size = 5'd8; mine_count = 9'd3; seed = 16'hACE1;
    chk("bp_stable", bad, 0);
    mine_ready = 1'b1;
    wait_done(d0, lat);
    repeat (3) @(posedge clk);
    #1;
    collect(b0, d0, v0);
    check_mines("bp", 8, 3, 3, 3);
    chk("bp_idle", busy, 0);
    chk("bp_prefix", q_diff(got, ref_q[0:2]), 0);

    // Reset mid-run after 3 mines, then a fresh placement
    @(posedge clk); #1;
    b0 = cap.size();
    seed = 16'hACE1; board_size = 5'd8; mine_count = 9'd10; safe_x = 4'd3; safe_y = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (cap.size() - b0 < 3 && k < 5000) begin @(posedge clk); #1; k++; end
    chk("mr_three", cap.size() - b0, 3);
    chk("mr_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", mine_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_xy", {mine_y, mine_x}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_run(16'hACE1, 5'd8, 9'd10, 4'd3, 4'd3, lat);
    check_mines("mr", 8, 10, 3, 3);
    chk("mr_same_seq", q_diff(got, ref_q), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mine_placer.md
MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 The block SHALL have parameter LFSR_WIDTH, default 16, giving the pseudo-random register width; the legal range SHALL be 8..64 and 2*COORD_W..64.
REQ-002 The block SHALL have parameter COORD_W, default 4, giving the per-axis coordinate width; the maximum board size SHALL be 2^COORD_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to place mines.
REQ-006 The block SHALL have port seed, input, LFSR_WIDTH bits: LFSR seed, sampled at start.
REQ-007 The block SHALL have port board_size, input, COORD_W+1 bits: side length N of the square board, sampled at start.
REQ-008 The block SHALL have port mine_count, input, 2*COORD_W+1 bits: requested mines, sampled at start.
REQ-009 The block SHALL have ports safe_x and safe_y, input, COORD_W bits each: first-click cell, sampled at start.
REQ-010 The block SHALL have ports mine_valid (output, 1), mine_ready (input, 1), mine_x (output, COORD_W) and mine_y (output, COORD_W): the mine write handshake to the board store.
REQ-011 The block SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-012 The pseudo-random next state SHALL be the XAPP052 Galois step of LFSR_WIDTH: shift right by 1, then XOR the width tap mask when the old bit 0 is 1.
REQ-013 The FSM SHALL have states IDLE, SEED, RUN, WRITE and DONE.
REQ-014 In IDLE, start SHALL latch the inputs, clear the occupancy bitmap (2^(2*COORD_W) bits) and the placed counter, and go to SEED; start SHALL be ignored outside IDLE.
REQ-015 In SEED, the LFSR SHALL load seed, or 1 if seed is 0; the target SHALL become min(mine_count, available cells).
REQ-016 The FSM SHALL go from SEED to DONE if the target is 0 or N is 0, and to RUN otherwise.
REQ-017 In RUN, the candidate SHALL be x = lfsr[COORD_W-1:0] and y = lfsr[2*COORD_W-1:COORD_W], and the LFSR SHALL advance exactly once per RUN cycle.
REQ-018 A candidate SHALL be rejected if x>=N, y>=N, its bitmap bit is set, or it is excluded (REQ-026/027); a rejected candidate SHALL keep the FSM in RUN.
REQ-019 An accepted candidate SHALL be registered onto mine_x/mine_y and move the FSM to WRITE in the next cycle.
REQ-020 In WRITE, mine_valid SHALL be 1 and mine_x/mine_y SHALL be stable until mine_ready; the LFSR SHALL hold.
REQ-021 On the WRITE handshake, the block SHALL set the bitmap bit and increment placed; it SHALL go to DONE if placed+1 equals the target, and back to RUN otherwise.
REQ-022 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-023 busy SHALL be 1 in SEED, RUN, WRITE and DONE, and 0 in IDLE.
REQ-024 No duplicate coordinate SHALL ever be emitted within one run.

Reset
REQ-025 With rst_n=0, asynchronously and including mid-run, the block SHALL force: state IDLE; lfsr 1; bitmap, placed and target 0; mine_valid, busy and done 0; mine_x and mine_y 0.

Configuration
REQ-026 With macro MINE_SAFE_ZONE_EN defined, the exclusion SHALL be the 3x3 block centred on (safe_x, safe_y), clipped at the board edges, and available cells SHALL be N*N minus the clipped zone size.
REQ-027 Without MINE_SAFE_ZONE_EN, the exclusion SHALL be the single cell (safe_x, safe_y), and available cells SHALL be N*N-1.

Verification
REQ-028 N=8, mine_count=10, seed=16'hACE1, mine_ready tied 1 -> exactly 10 handshakes, all distinct, all coordinates <8, none at the safe cell, then one done pulse.
REQ-029 N=3, mine_count=20, safe=(1,1), MINE_SAFE_ZONE_EN off -> 8 mines covering every cell except (1,1); with the macro on -> 0 mines and done within 3 cycles of start.
REQ-030 seed=0, N=16, mine_count=40 -> identical mine sequence to a run with seed=1.
REQ-031 mine_ready held 0 for 5 cycles during WRITE -> mine_valid stays 1 with stable x/y; a start pulse in that window is ignored.
REQ-032 rst_n pulsed low after 3 mines are placed -> all outputs are 0 immediately; a new start runs a complete fresh placement.
REQ-033 mine_count=0 -> done is asserted 2 cycles after start, with no mine_valid.
